// File: rtl/cache_pkg.sv
// Shared state encodings and line-field layout for the N-way LRU cache.
// A line is {valid, dirty, tag, data[127:0]}, with data in the low bits.
`timescale 1ns/1ps
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COMP  = 2'd1,
    ST_WBACK = 2'd2,
    ST_ALLOC = 2'd3
  } state_e;

  localparam int DATA_LSB = 0;
  localparam int DATA_W   = 128;
  localparam int TAG_LSB  = 128;
  localparam int LINE_OVH = 130;

  function automatic int line_w(input int tag_size);
    return LINE_OVH + tag_size;
  endfunction

  function automatic int dirty_bit(input int tag_size);
    return TAG_LSB + tag_size;
  endfunction

  function automatic int valid_bit(input int tag_size);
    return TAG_LSB + tag_size + 1;
  endfunction

endpackage

// File: rtl/cache_lru_set.sv
// True-LRU age update and victim choice for one set; purely combinational, 0 cycles.
// No flow control: the caller decides when the returned ages and victim are used.
`timescale 1ns/1ps
module cache_lru_set #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_BITS = 2
) (
  input  logic [NUM_WAYS-1:0][WAY_BITS-1:0] age_i,
  input  logic [NUM_WAYS-1:0]               hit_i,
  input  logic [NUM_WAYS-1:0]               valid_i,
  output logic [NUM_WAYS-1:0][WAY_BITS-1:0] age_o,
  output logic [WAY_BITS-1:0]               victim_o
);

  localparam logic [WAY_BITS-1:0] OLDEST = WAY_BITS'(NUM_WAYS - 1);

  logic [WAY_BITS-1:0] hit_age;
  logic                any_hit;
  logic                found;

  always_comb begin
    hit_age = '0;
    any_hit = |hit_i;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_i[w]) hit_age = hit_age | age_i[w];
    end
    // Younger ways age by one, the hit way becomes youngest: ages stay a permutation.
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (hit_i[w]) begin
        age_o[w] = '0;
      end else if (any_hit && (age_i[w] < hit_age)) begin
        age_o[w] = age_i[w] + WAY_BITS'(1);
      end else begin
        age_o[w] = age_i[w];
      end
    end
  end

  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = WAY_BITS'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (age_i[w] == OLDEST) victim_o = WAY_BITS'(w);
      end
    end
  end

endmodule

// File: rtl/cache_nway_lru.sv
// N-way set-associative write-back/write-allocate cache with true-LRU replacement and hit/miss stats.
// Hits return in 0 cycles; misses stall the pipeline until the (optional) writeback and fill complete.
`timescale 1ns/1ps
module cache_nway_lru
  import cache_pkg::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int WAY_BITS = 2,
  parameter int NUM_SETS = 4,
  parameter int SET_BITS = 2,
  parameter int TAG_SIZE = 28 - SET_BITS
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [31:0]  stat_hit,
  output logic [31:0]  stat_miss
);

  localparam int LINE_W    = line_w(TAG_SIZE);
  localparam int DIRTY_BIT = dirty_bit(TAG_SIZE);
  localparam int VALID_BIT = valid_bit(TAG_SIZE);

  typedef logic [LINE_W-1:0]                 line_t;
  typedef logic [NUM_WAYS-1:0][WAY_BITS-1:0] ages_t;

  state_e              state_q, state_d;
  line_t               line_q [NUM_SETS][NUM_WAYS];
  line_t               line_d [NUM_SETS][NUM_WAYS];
  ages_t               age_q  [NUM_SETS];
  ages_t               age_d  [NUM_SETS];
  logic [WAY_BITS-1:0] victim_q, victim_d;
  logic [31:0]         stat_hit_q, stat_hit_d;
  logic [31:0]         stat_miss_q, stat_miss_d;
  logic                mem_ready_ff;
  logic [127:0]        mem_rdata_ff;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_SIZE-1:0] req_tag;
  logic [1:0]          word_idx;
  logic                req;
  logic [NUM_WAYS-1:0] valid_vec, hit_vec;
  logic                hit_any;
  logic [WAY_BITS-1:0] hit_way;
  logic                victim_dirty;
  ages_t               lru_age;
  logic [WAY_BITS-1:0] lru_victim;

  assign set_idx  = proc_addr[SET_BITS+1:2];
  assign req_tag  = proc_addr[29:30-TAG_SIZE];
  assign word_idx = proc_addr[1:0];
  assign req      = proc_read | proc_write;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      valid_vec[w] = line_q[set_idx][w][VALID_BIT];
      hit_vec[w]   = valid_vec[w] && (line_q[set_idx][w][TAG_LSB +: TAG_SIZE] == req_tag);
      if (hit_vec[w]) hit_way = hit_way | WAY_BITS'(w);
    end
    hit_any      = |hit_vec;
    victim_dirty = line_q[set_idx][lru_victim][VALID_BIT] && line_q[set_idx][lru_victim][DIRTY_BIT];
  end

  cache_lru_set #(
    .NUM_WAYS (NUM_WAYS),
    .WAY_BITS (WAY_BITS)
  ) u_lru (
    .age_i    (age_q[set_idx]),
    .hit_i    (hit_vec),
    .valid_i  (valid_vec),
    .age_o    (lru_age),
    .victim_o (lru_victim)
  );

  always_ff @(posedge clk) begin
    if (proc_reset) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_COMP;
      ST_COMP:  if (req && !hit_any) state_d = victim_dirty ? ST_WBACK : ST_ALLOC;
      ST_WBACK: if (mem_ready_ff) state_d = ST_ALLOC;
      ST_ALLOC: if (mem_ready_ff) state_d = ST_COMP;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    proc_stall = !((state_q == ST_COMP) && hit_any) && req;
    proc_rdata = hit_any ? line_q[set_idx][hit_way][{word_idx, 5'b0} +: 32] : 32'd0;
    mem_read   = (state_q == ST_ALLOC) && !mem_ready_ff;
    mem_write  = (state_q == ST_WBACK) && !mem_ready_ff;
    mem_wdata  = line_q[set_idx][victim_q][DATA_LSB +: DATA_W];
    if (state_q == ST_WBACK) mem_addr = {line_q[set_idx][victim_q][TAG_LSB +: TAG_SIZE], set_idx};
    else                     mem_addr = proc_addr[29:2];
  end

  always_comb begin
    line_d      = line_q;
    age_d       = age_q;
    victim_d    = victim_q;
    stat_hit_d  = stat_hit_q;
    stat_miss_d = stat_miss_q;
    case (state_q)
      ST_COMP: begin
        if (req && hit_any) begin
          stat_hit_d     = stat_hit_q + 32'd1;
          age_d[set_idx] = lru_age;
          if (proc_write) begin
            line_d[set_idx][hit_way][{word_idx, 5'b0} +: 32] = proc_wdata;
            line_d[set_idx][hit_way][DIRTY_BIT]               = 1'b1;
          end
        end else if (req) begin
          stat_miss_d = stat_miss_q + 32'd1;
          victim_d    = lru_victim;
        end
      end
      ST_WBACK: if (mem_ready_ff) line_d[set_idx][victim_q][DIRTY_BIT] = 1'b0;
      // Ages are left alone here; the hit that retires the request promotes the new line.
      ST_ALLOC: if (mem_ready_ff) line_d[set_idx][victim_q] = {1'b1, 1'b0, req_tag, mem_rdata_ff};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          line_q[s][w]   <= '0;
          age_q[s][w]    <= WAY_BITS'(w);
        end
      end
      victim_q     <= '0;
      stat_hit_q   <= '0;
      stat_miss_q  <= '0;
      mem_ready_ff <= 1'b0;
      mem_rdata_ff <= '0;
    end else begin
      line_q       <= line_d;
      age_q        <= age_d;
      victim_q     <= victim_d;
      stat_hit_q   <= stat_hit_d;
      stat_miss_q  <= stat_miss_d;
      mem_ready_ff <= mem_ready;
      mem_rdata_ff <= mem_rdata;
    end
  end

  assign stat_hit  = stat_hit_q;
  assign stat_miss = stat_miss_q;

endmodule
